// File: rtl/uart_tx_fifo.sv
// Purpose : FIFO-buffered UART transmitter (start, UART_Nbit data LSB first, optional parity, 1-2 stop bits).
// Latency : a word written into an idle, empty block at edge N drives the start bit from edge N+1.
// Backpr. : none; a write while full is dropped and flagged with a one-cycle overflow pulse.
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous, active-high; forces the line high immediately
//   wr_en/wr_data  push request and word to transmit
//   full/empty     registered FIFO status flags
//   level          FIFO occupancy (0..FIFO_DEPTH)
//   overflow       one-cycle pulse after a rejected write
//   SerialDataOut  registered serial line, idles high
//   tx_busy        high while a frame is on the line
//   tx_done        high during the last clock of the final stop bit
module uart_tx_fifo #(
    parameter int UART_Nbit   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int baudrate    = 9600,
    parameter int clk_freq    = 50000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [UART_Nbit-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          SerialDataOut,
    output logic                          tx_busy,
    output logic                          tx_done
);

    localparam int BAUD_DIV = clk_freq / baudrate;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic PAR_ODD = (PARITY_MODE == 2);

    // Elaboration-time parameter sanity checks.
    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_fifo: clk_freq/baudrate must be at least 2");
    end
    if (UART_Nbit < 5 || UART_Nbit > 9) begin : g_bad_nbit
        $error("uart_tx_fifo: UART_Nbit must be in 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [UART_Nbit-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 overflow_q, overflow_d;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [UART_Nbit-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic [UART_Nbit-1:0] head_word;

    assign head_word = mem_q[rd_ptr_q];
    assign bit_end   = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));
    assign last_data = (bit_cnt_q == 4'(UART_Nbit - 1));
    assign last_stop = (bit_cnt_q == 4'(STOP_BITS - 1));

    // ------------------------------------------------------------------
    // FIFO bookkeeping. The write decision uses the registered full flag,
    // so a pop at the same edge cannot rescue a write into a full FIFO.
    // ------------------------------------------------------------------
    always_comb begin
        push       = wr_en & ~full_q;
        overflow_d = wr_en & full_q;

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        full_d  = (level_d == LVL_W'(FIFO_DEPTH));
        empty_d = (level_d == '0);
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. Loading a word (from IDLE or at the end of the
    // final stop bit) pops the FIFO head and enters START at the same edge,
    // which is what gives back-to-back frames with no idle gap.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pop       = 1'b0;

        if (state_q == IDLE || bit_end) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop       = 1'b1;
                    shift_d   = head_word;
                    par_d     = ^head_word;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end

            START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end

            DATA: begin
                if (bit_end) begin
                    // Shift right so the next data bit sits at bit 0.
                    shift_d = shift_q >> 1;
                    if (last_data) begin
                        bit_cnt_d = '0;
                        if (PARITY_MODE != 0) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        if (!empty_q) begin
                            pop       = 1'b1;
                            shift_d   = head_word;
                            par_d     = ^head_word;
                            bit_cnt_d = '0;
                            state_d   = START;
                        end else begin
                            bit_cnt_d = '0;
                            state_d   = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs. The line value is computed for the state being entered
    // and captured in tx_q, so SerialDataOut comes straight from a flop.
    // ------------------------------------------------------------------
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d ^ PAR_ODD;
            default: tx_d = 1'b1;
        endcase

        tx_busy = (state_q != IDLE);
        tx_done = (state_q == STOP) && bit_end && last_stop;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    // Storage needs no reset: pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full          = full_q;
    assign empty         = empty_q;
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign SerialDataOut = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;

    logic       e_wr_en, o_wr_en;
    logic [7:0] e_wr_data, o_wr_data;
    logic       e_full, e_empty, e_ovf, e_line, e_busy, e_done;
    logic       o_full, o_empty, o_ovf, o_line, o_busy, o_done;
    logic [2:0] e_level, o_level;

    int checks   = 0;
    int failures = 0;

    // Six-write burst: words, then level/full/overflow after each edge.
    logic [7:0] burst_word [6] = '{8'hA1, 8'h3C, 8'h0F, 8'hC3, 8'h7E, 8'hEE};
    int         exp_lvl    [6] = '{1, 1, 2, 3, 4, 4};
    int         exp_full   [6] = '{0, 0, 0, 0, 1, 1};
    int         exp_ovf    [6] = '{0, 0, 0, 0, 0, 1};

    always #5 clk = ~clk;

    // Even parity, one stop bit.
    uart_tx_fifo #(
        .UART_Nbit(8), .FIFO_DEPTH(4), .PARITY_MODE(1), .STOP_BITS(1),
        .baudrate(5), .clk_freq(50)
    ) u_even (
        .clk(clk), .reset(reset), .wr_en(e_wr_en), .wr_data(e_wr_data),
        .full(e_full), .empty(e_empty), .level(e_level), .overflow(e_ovf),
        .SerialDataOut(e_line), .tx_busy(e_busy), .tx_done(e_done)
    );

    // Odd parity, two stop bits.
    uart_tx_fifo #(
        .UART_Nbit(8), .FIFO_DEPTH(4), .PARITY_MODE(2), .STOP_BITS(2),
        .baudrate(5), .clk_freq(50)
    ) u_odd (
        .clk(clk), .reset(reset), .wr_en(o_wr_en), .wr_data(o_wr_data),
        .full(o_full), .empty(o_empty), .level(o_level), .overflow(o_ovf),
        .SerialDataOut(o_line), .tx_busy(o_busy), .tx_done(o_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line bits of one frame, index 0 = start bit.
    function automatic logic [15:0] make_frame(input logic [7:0] d, input int pmode, input int nstop);
        logic [15:0] f;
        int          n;
        f = '0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        n = 9;
        if (pmode != 0) begin
            f[9] = (^d) ^ (pmode == 2);
            n = 10;
        end
        for (int s = 0; s < nstop; s++) f[n + s] = 1'b1;
        return f;
    endfunction

    // Called at the first sample of a frame's start bit; checks every cycle
    // of the frame and returns at the first sample after it.
    task automatic run_frame(input int sel, input string name, input logic [15:0] frame, input int nbits);
        logic line, done, busy;
        for (int k = 0; k < nbits * 10; k++) begin
            line = (sel == 0) ? e_line : o_line;
            done = (sel == 0) ? e_done : o_done;
            busy = (sel == 0) ? e_busy : o_busy;
            check($sformatf("%s_line_k%0d", name, k), line, frame[k / 10]);
            check($sformatf("%s_done_k%0d", name, k), done, (k == nbits * 10 - 1));
            check($sformatf("%s_busy_k%0d", name, k), busy, 1);
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        e_wr_en   = 1'b0;
        o_wr_en   = 1'b0;
        e_wr_data = '0;
        o_wr_data = '0;

        // ---------------- reset state ----------------
        step();
        check("rst_e_line",  e_line,  1);
        check("rst_e_busy",  e_busy,  0);
        check("rst_e_done",  e_done,  0);
        check("rst_e_ovf",   e_ovf,   0);
        check("rst_e_full",  e_full,  0);
        check("rst_e_empty", e_empty, 1);
        check("rst_e_level", e_level, 0);
        check("rst_o_line",  o_line,  1);
        check("rst_o_empty", o_empty, 1);
        step();
        reset = 1'b0;
        step();
        check("idle_e_line", e_line, 1);
        check("idle_e_busy", e_busy, 0);

        // ---------------- even parity frame, 0x55 ----------------
        e_wr_data = 8'h55;
        e_wr_en   = 1'b1;
        step();
        e_wr_en = 1'b0;
        check("w55_level",    e_level, 1);
        check("w55_empty",    e_empty, 0);
        check("w55_line_pre", e_line,  1);
        check("w55_busy_pre", e_busy,  0);
        step();
        run_frame(0, "even55", 16'h04AA, 11);
        check("even55_busy_after",  e_busy,  0);
        check("even55_empty_after", e_empty, 1);
        check("even55_line_after",  e_line,  1);
        check("even55_done_after",  e_done,  0);

        // ---------------- odd parity, two stop bits, 0x03 ----------------
        o_wr_data = 8'h03;
        o_wr_en   = 1'b1;
        step();
        o_wr_en = 1'b0;
        check("w03_line_pre", o_line, 1);
        step();
        run_frame(1, "odd03", 16'h0E06, 12);
        check("odd03_busy_after", o_busy, 0);
        check("odd03_line_after", o_line, 1);
        check("odd03_done_after", o_done, 0);

        // ---------------- six consecutive writes ----------------
        for (int i = 0; i < 6; i++) begin
            e_wr_data = burst_word[i];
            e_wr_en   = 1'b1;
            step();
            check($sformatf("burst%0d_level", i), e_level, exp_lvl[i]);
            check($sformatf("burst%0d_full", i),  e_full,  exp_full[i]);
            check($sformatf("burst%0d_ovf", i),   e_ovf,   exp_ovf[i]);
        end
        e_wr_en = 1'b0;
        step();
        check("burst_ovf_drop",  e_ovf,   0);
        check("burst_level_hold", e_level, 4);

        // First word started at burst edge 2; its last stop cycle follows edge 111.
        repeat (104) step();
        check("w0_last_done",  e_done,  1);
        check("w0_last_full",  e_full,  1);
        check("w0_last_level", e_level, 4);

        // Write while full at the same edge as the pop.
        e_wr_data = 8'h99;
        e_wr_en   = 1'b1;
        step();
        e_wr_en = 1'b0;
        check("wpop_ovf",   e_ovf,   1);
        check("wpop_level", e_level, 3);
        check("wpop_full",  e_full,  0);

        // Remaining words leave in write order, back to back.
        run_frame(0, "b2b_3C", make_frame(8'h3C, 1, 1), 11);
        run_frame(0, "b2b_0F", make_frame(8'h0F, 1, 1), 11);
        run_frame(0, "b2b_C3", make_frame(8'hC3, 1, 1), 11);
        run_frame(0, "b2b_7E", make_frame(8'h7E, 1, 1), 11);
        check("b2b_busy_after",  e_busy,  0);
        check("b2b_empty_after", e_empty, 1);
        check("b2b_level_after", e_level, 0);
        check("b2b_line_after",  e_line,  1);

        // ---------------- reset mid-frame ----------------
        o_wr_data = 8'h00;
        o_wr_en   = 1'b1;
        step();
        o_wr_data = 8'hF0;
        step();
        o_wr_en = 1'b0;
        check("mid_level", o_level, 1);
        check("mid_start", o_line,  0);
        repeat (35) step();
        check("mid_line_before", o_line, 0);
        check("mid_busy_before", o_busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_line",  o_line,  1);
        check("mid_rst_busy",  o_busy,  0);
        check("mid_rst_level", o_level, 0);
        check("mid_rst_empty", o_empty, 1);
        check("mid_rst_done",  o_done,  0);
        step();
        check("mid_rst_line_held", o_line, 1);
        reset = 1'b0;
        for (int c = 0; c < 150; c++) begin
            step();
            check($sformatf("post_rst_line_c%0d", c), o_line, 1);
            check($sformatf("post_rst_done_c%0d", c), o_done, 0);
        end
        check("post_rst_busy",  o_busy,  0);
        check("post_rst_level", o_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
